// File: rtl/sram_pkt_writer.sv
// Packs a byte stream from the WRR FIFO output stage into 16-bit SRAM writes with byte
// enables, one packet at a time, and reports a done/status pulse per packet.
module sram_pkt_writer #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_BIT     = 14,
   parameter int DATA_NUMBIT  = 8,
   parameter int PRIORITY_BIT = 3,
   parameter int TIMEOUT      = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_ena,
   input  logic                      rd_ena,
   input  logic                      o_sop,
   input  logic                      o_eop,
   input  logic [DATA_WIDTH-1:0]     o_data,
   input  logic [ADDR_BIT-1:0]       addr,
   input  logic [DATA_NUMBIT-1:0]    data_width,
   input  logic [PRIORITY_BIT-1:0]   prior_o,
   output logic                      ready,
   output logic                      sram_cs_n,
   output logic                      sram_we_n,
   output logic [ADDR_BIT-2:0]       sram_addr,
   output logic [2*DATA_WIDTH-1:0]   sram_wdata,
   output logic [1:0]                sram_be_n,
   output logic                      pkt_done,
   output logic [PRIORITY_BIT-1:0]   pkt_prior,
   output logic                      pkt_err,
   output logic                      proto_err
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [DATA_WIDTH-1:0] ZERO_BYTE = '0;

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t                   state_reg, state_next;
   logic [ADDR_BIT-1:0]      bp_reg;
   logic [DATA_NUMBIT-1:0]   len_reg;
   logic [PRIORITY_BIT-1:0]  pri_reg;
   logic [DATA_NUMBIT:0]     cnt_reg;
   logic [DATA_WIDTH-1:0]    lo_reg;
   logic                     lo_vld_reg;
   logic                     err_reg;
   logic [TW-1:0]            idle_reg;

   logic                     cap, first, abort, stray, lo_pend;
   logic [ADDR_BIT-1:0]      cap_addr;
   logic                     wr_go;
   logic [ADDR_BIT-2:0]      wr_word;
   logic [2*DATA_WIDTH-1:0]  wr_data;
   logic [1:0]               wr_be_n;

   // Next state and byte-capture decisions; abort covers truncation and timeout.
   always_comb begin
      state_next = state_reg;
      cap        = 1'b0;
      first      = 1'b0;
      abort      = 1'b0;
      stray      = 1'b0;
      cap_addr   = bp_reg;
      case (state_reg)
         IDLE: begin
            if (wr_ena) begin
               if (o_sop && ready) begin
                  cap        = 1'b1;
                  first      = 1'b1;
                  cap_addr   = addr;
                  state_next = o_eop ? DONE : WRITE;
               end else begin
                  stray = 1'b1;
               end
            end
         end
         WRITE: begin
            if (wr_ena && o_sop) begin
               abort      = 1'b1;
               state_next = DONE;
            end else if (wr_ena) begin
               cap = 1'b1;
               if (o_eop) state_next = DONE;
            end else if (idle_reg == TMO_LAST) begin
               abort      = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            stray      = wr_ena;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A pending low lane always belongs to the same word as the next (odd) byte.
   always_comb begin
      lo_pend = lo_vld_reg && !first;
      wr_go   = 1'b0;
      wr_word = '0;
      wr_data = '0;
      wr_be_n = 2'b11;
      if (cap && (cap_addr[0] || o_eop)) begin
         wr_go   = 1'b1;
         wr_word = cap_addr[ADDR_BIT-1:1];
         if (cap_addr[0]) begin
            wr_data = {o_data, (lo_pend ? lo_reg : ZERO_BYTE)};
            wr_be_n = {1'b0, !lo_pend};
         end else begin
            wr_data = {ZERO_BYTE, o_data};
            wr_be_n = 2'b10;
         end
      end else if (abort && lo_vld_reg) begin
         wr_go   = 1'b1;
         wr_word = bp_reg[ADDR_BIT-1:1];
         wr_data = {ZERO_BYTE, lo_reg};
         wr_be_n = 2'b10;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         bp_reg     <= '0;
         len_reg    <= '0;
         pri_reg    <= '0;
         cnt_reg    <= '0;
         lo_reg     <= '0;
         lo_vld_reg <= 1'b0;
         err_reg    <= 1'b0;
         idle_reg   <= '0;
         ready      <= 1'b1;
         sram_cs_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_addr  <= '0;
         sram_wdata <= '0;
         sram_be_n  <= 2'b11;
         pkt_done   <= 1'b0;
         pkt_prior  <= '0;
         pkt_err    <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         state_reg <= state_next;
         ready     <= (state_reg == IDLE) && (state_next == IDLE);
         proto_err <= stray || (rd_ena && wr_ena);
         sram_cs_n <= !wr_go;
         sram_we_n <= !wr_go;
         sram_be_n <= wr_be_n;
         if (wr_go) begin
            sram_addr  <= wr_word;
            sram_wdata <= wr_data;
         end
         if (cap) begin
            bp_reg <= cap_addr + 1'b1;
            if (first)              cnt_reg <= 1;
            else if (cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
            if (!cap_addr[0] && !o_eop) begin
               lo_reg     <= o_data;
               lo_vld_reg <= 1'b1;
            end else begin
               lo_vld_reg <= 1'b0;
            end
         end
         if (first) begin
            len_reg <= data_width;
            pri_reg <= prior_o;
            err_reg <= 1'b0;
         end
         if (abort) begin
            err_reg    <= 1'b1;
            lo_vld_reg <= 1'b0;
         end
         idle_reg <= (state_reg == WRITE && !wr_ena) ? idle_reg + 1'b1 : '0;
         pkt_done <= (state_reg == DONE);
         if (state_reg == DONE) begin
            pkt_prior <= pri_reg;
            pkt_err   <= err_reg || (cnt_reg != {1'b0, len_reg}) || (len_reg == '0);
         end
      end
   end

endmodule
